// File: rtl/yl3_pkg.sv
// Shared constants and types for the YL-3 serial display snooper.
package yl3_pkg;

    localparam int unsigned WORD_BITS = 16;
    localparam int unsigned DIGITS    = 8;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned FRAME_W   = DIGITS * 8;

    localparam logic [7:0] BLANK_DEF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        OVERRUN = 2'd2
    } state_t;

endpackage

// File: rtl/yl3_if.sv
// Pin-level and decoded-result bundle between a YL-3 driver side and the receiver.
interface yl3_if;
    import yl3_pkg::*;

    logic               sck;
    logic               dio;
    logic               rck;
    logic [FRAME_W-1:0] frame;
    logic [7:0]         last_seg;
    logic [7:0]         last_sel;
    logic               word_valid;
    logic               frame_valid;
    logic               err;

    modport master (
        output sck, dio, rck,
        input  frame, last_seg, last_sel, word_valid, frame_valid, err
    );

    modport slave (
        input  sck, dio, rck,
        output frame, last_seg, last_sel, word_valid, frame_valid, err
    );

endinterface

// File: rtl/yl3_pin_sync.sv
// Synchroniser, history flop and registered rising-edge detect for one pin.
// level_o is the history flop so data sampled with it lines up with rise_o.
module yl3_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_q;

    // Synchroniser chain, history flop and edge register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
        end
    end

    assign level_o = hist_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/yl3_rx.sv
// Snoops SCK/DIO/RCK of a YL-3 driver and rebuilds latched words and the 8-digit frame.
module yl3_rx
    import yl3_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter logic [7:0]  BLANK       = BLANK_DEF
) (
    input  logic  clk,
    input  logic  rst,
    yl3_if.slave  pins
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic sck_rise, rck_rise, dio_lvl;
    logic sck_lvl, rck_lvl, dio_rise;
    logic unused_sync;

    state_t               state_q, state_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [7:0]           last_seg_q, last_seg_d;
    logic [7:0]           last_sel_q, last_sel_d;
    logic [DIGITS-1:0]    seen_q, seen_d;
    logic                 word_valid_q, word_valid_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 err_q, err_d;

    logic [WORD_BITS-1:0] sh;
    logic [CNT_W-1:0]     cnt_sh;
    logic [DIGITS-1:0]    seen_n;

    yl3_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clk(clk), .rst(rst), .pin_i(pins.sck), .level_o(sck_lvl), .rise_o(sck_rise)
    );
    yl3_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dio (
        .clk(clk), .rst(rst), .pin_i(pins.dio), .level_o(dio_lvl), .rise_o(dio_rise)
    );
    yl3_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rck (
        .clk(clk), .rst(rst), .pin_i(pins.rck), .level_o(rck_lvl), .rise_o(rck_rise)
    );

    assign unused_sync = ^{sck_lvl, rck_lvl, dio_rise};

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            tmo_q         <= '0;
            frame_q       <= {DIGITS{BLANK}};
            last_seg_q    <= BLANK;
            last_sel_q    <= '0;
            seen_q        <= '0;
            word_valid_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            frame_q       <= frame_d;
            last_seg_q    <= last_seg_d;
            last_sel_q    <= last_sel_d;
            seen_q        <= seen_d;
            word_valid_q  <= word_valid_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
        end
    end

    // Next state: shift first, then latch evaluation or timeout.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        frame_d       = frame_q;
        last_seg_d    = last_seg_q;
        last_sel_d    = last_sel_q;
        seen_d        = seen_q;
        word_valid_d  = 1'b0;
        frame_valid_d = 1'b0;
        err_d         = 1'b0;
        seen_n        = seen_q;
        sh            = shreg_q;
        cnt_sh        = cnt_q;

        if (sck_rise) begin
            sh     = {shreg_q[WORD_BITS-2:0], dio_lvl};
            cnt_sh = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
        shreg_d = sh;
        cnt_d   = cnt_sh;

        if (rck_rise) begin
            state_d = IDLE;
            tmo_d   = '0;
            cnt_d   = '0;
            if (cnt_sh == CNT_W'(WORD_BITS)) begin
                word_valid_d = 1'b1;
                last_seg_d   = sh[WORD_BITS-1 -: 8];
                last_sel_d   = sh[7:0];
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (sh[i]) frame_d[(int'(DIGITS) - 1 - i) * 8 +: 8] = sh[WORD_BITS-1 -: 8];
                end
                seen_n = seen_q | sh[7:0];
                if (seen_n == '1) begin
                    frame_valid_d = 1'b1;
                    seen_d        = '0;
                end else begin
                    seen_d = seen_n;
                end
            end else begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    tmo_d = '0;
                    if (sck_rise) state_d = SHIFT;
                end
                SHIFT, OVERRUN: begin
                    if (sck_rise) begin
                        tmo_d = '0;
                        if (cnt_sh > CNT_W'(WORD_BITS)) state_d = OVERRUN;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        tmo_d   = '0;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pins.frame       = frame_q;
    assign pins.last_seg    = last_seg_q;
    assign pins.last_sel    = last_sel_q;
    assign pins.word_valid  = word_valid_q;
    assign pins.frame_valid = frame_valid_q;
    assign pins.err         = err_q;

endmodule

// File: tb/tb_yl3_rx.sv
// Directed bench for yl3_rx with a byte-array frame model and per-cycle output compare.
module tb_yl3_rx;
    import yl3_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    yl3_if bus();

    yl3_rx dut (
        .clk  (clk),
        .rst  (rst),
        .pins (bus.slave)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: one byte per digit plus pulse counters.
    logic [7:0] m_dig [8];
    logic [7:0] m_seg, m_sel, m_seen;
    int e_wv = 0, e_err = 0, e_fv = 0;
    int a_wv = 0, a_err = 0, a_fv = 0;
    bit steady  = 1'b0;
    bit saw_ovr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_frame();
        logic [63:0] f = '0;
        for (int d = 0; d < 8; d++) f = {f[55:0], m_dig[d]};
        return f;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 8; d++) m_dig[d] = 8'hFF;
        m_seg  = 8'hFF;
        m_sel  = 8'h00;
        m_seen = 8'h00;
    endtask

    task automatic model_latch(input int n, input logic [15:0] w);
        if (n == 16) begin
            e_wv++;
            m_seg = w[15:8];
            m_sel = w[7:0];
            for (int d = 0; d < 8; d++) if (m_sel[d]) m_dig[d] = m_seg;
            m_seen = m_seen | m_sel;
            if (m_seen == 8'hFF) begin
                e_fv++;
                m_seen = 8'h00;
            end
        end else begin
            e_err++;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.dio = bits[i];
            cyc(2);
            bus.sck = 1'b1;
            cyc(4);
            bus.sck = 1'b0;
            cyc(4);
        end
    endtask

    task automatic pulse_rck();
        bus.rck = 1'b1;
        cyc(4);
        bus.rck = 1'b0;
        cyc(4);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_wv_cnt"},  64'(a_wv),  64'(e_wv));
        chk({tag, "_err_cnt"}, 64'(a_err), 64'(e_err));
        chk({tag, "_fv_cnt"},  64'(a_fv),  64'(e_fv));
    endtask

    task automatic xfer(input int n, input logic [31:0] bits, input string tag);
        steady = 1'b0;
        send_bits(bits, n);
        pulse_rck();
        cyc(6);
        model_latch(n, bits[15:0]);
        check_counts(tag);
        steady = 1'b1;
    endtask

    // Per-cycle compare and pulse accounting.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.word_valid)  a_wv++;
            if (bus.err)         a_err++;
            if (bus.frame_valid) a_fv++;
            if (dut.state_q == OVERRUN) saw_ovr = 1'b1;
            chk("wv_err_excl", 64'(bus.word_valid & bus.err), 64'd0);
            chk("fv_needs_wv", 64'(bus.frame_valid & ~bus.word_valid), 64'd0);
            if (steady) begin
                chk("frame",    bus.frame,          m_frame());
                chk("last_seg", 64'(bus.last_seg),  64'(m_seg));
                chk("last_sel", 64'(bus.last_sel),  64'(m_sel));
            end
        end
    end

    initial begin
        logic [15:0] w;
        bus.sck = 1'b0;
        bus.dio = 1'b0;
        bus.rck = 1'b0;
        model_reset();
        cyc(5);
        chk("rst_frame",    bus.frame,            64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_last_seg", 64'(bus.last_seg),    64'hFF);
        chk("rst_last_sel", 64'(bus.last_sel),    64'h00);
        chk("rst_pulses",   64'({bus.word_valid, bus.frame_valid, bus.err}), 64'd0);
        rst = 1'b0;
        steady = 1'b1;
        cyc(3);

        // Single word to digit 0.
        xfer(16, 32'h0000_C001, "t1");
        chk("t1_frame_lit", bus.frame,         64'hC0FF_FFFF_FFFF_FFFF);
        chk("t1_sel_lit",   64'(bus.last_sel), 64'h01);

        // One word per digit; frame completes on the eighth.
        for (int k = 0; k < 8; k++) begin
            w[15:8] = 8'(k);
            w[7:0]  = 8'(1 << k);
            xfer(16, 32'(w), "t2");
        end
        chk("t2_frame_lit", bus.frame, 64'h0001_0203_0405_0607);
        chk("t2_fv_lit",    64'(a_fv), 64'd1);

        // Short word, long word, then a good one.
        xfer(15, 32'h0000_1234, "t3s");
        chk("t3_err_lit", 64'(a_err), 64'd1);
        xfer(17, 32'h0001_ABCD, "t3l");
        chk("t3_overrun", 64'(saw_ovr), 64'd1);
        xfer(16, 32'h0000_7E20, "t3g");

        // Partial word abandoned by timeout.
        steady = 1'b0;
        send_bits(32'h0000_00A5, 8);
        cyc(4200);
        chk("t4_idle", 64'(dut.state_q == IDLE), 64'd1);
        e_err++;
        check_counts("t4");
        steady = 1'b1;
        xfer(16, 32'h0000_5A04, "t4g");

        // Empty select then all-digit select.
        xfer(16, 32'h0000_0000, "t5z");
        xfer(16, 32'h0000_3FFF, "t5f");
        chk("t5_frame_lit", bus.frame, {8{8'h3F}});
        chk("t5_fv_lit",    64'(a_fv), 64'd2);

        // Reset in the middle of a word.
        steady = 1'b0;
        send_bits(32'h0000_0155, 10);
        rst = 1'b1;
        cyc(3);
        chk("t6_rst_frame", bus.frame,         64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_rst_seg",   64'(bus.last_seg), 64'hFF);
        chk("t6_rst_sel",   64'(bus.last_sel), 64'h00);
        rst = 1'b0;
        model_reset();
        cyc(6);
        check_counts("t6r");
        steady = 1'b1;
        xfer(16, 32'h0000_6D10, "t6g");

        // Sixteenth SCK rise coincides with RCK rise.
        w = 16'h4F08;
        steady = 1'b0;
        send_bits(32'(w[15:1]), 15);
        bus.dio = w[0];
        cyc(2);
        bus.sck = 1'b1;
        bus.rck = 1'b1;
        cyc(4);
        bus.sck = 1'b0;
        bus.rck = 1'b0;
        cyc(10);
        model_latch(16, w);
        check_counts("t7");
        steady = 1'b1;
        chk("t7_seg_lit", 64'(bus.last_seg), 64'h4F);
        chk("t7_sel_lit", 64'(bus.last_sel), 64'h08);
        cyc(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
